// File: rtl/eq_pkg.sv
// Shared definitions for the ADC -> equalizer -> DAC sample path.
// Holds the ADC word width and the offset-binary to two's-complement mapping.
package eq_pkg;

  localparam int ADC_W     = 12;
  localparam int MAX_OUT_W = 24;

  // Flipping the MSB turns offset binary into two's complement; the shift
  // left-justifies the word so it reads as Q1.(out_w-1) in the low out_w bits.
  function automatic logic [MAX_OUT_W-1:0] offset_to_q(
    input logic [ADC_W-1:0] data,
    input int               out_w
  );
    logic [MAX_OUT_W-1:0] word;
    word = MAX_OUT_W'({~data[ADC_W-1], data[ADC_W-2:0]});
    return word << (out_w - ADC_W);
  endfunction

endpackage

// File: rtl/adc_sample_conditioner_sync_fifo.sv
// Single-clock FIFO with a combinational head read and an occupancy count.
// The caller must only push when there is room, or when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // NOTE: storage has no reset; level gates every read, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/adc_sample_conditioner.sv
// Captures one ADC conversion per rx_done rising edge, converts it to left-justified
// two's complement and queues it for the equalizer over a valid/ready handshake.
module adc_sample_conditioner
  import eq_pkg::*;
#(
  parameter int OUT_W = 16,
  parameter int DEPTH = 8,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             rx_done,
  input  logic [ADC_W-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [LW-1:0]    level,
  output logic             overflow,
  input  logic             clr_ovf
);

  logic             rx_done_q;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             drop;
  logic             full;
  logic             empty;
  logic [OUT_W-1:0] sample;
  logic [OUT_W-1:0] head;
  logic [MAX_OUT_W-1:0] sample_wide;

  // rx_done is a level; tracking it regardless of en means a rise missed while
  // disabled is not picked up later when en goes high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_done_q <= 1'b0;
    else     rx_done_q <= rx_done;
  end

  assign push_req = en && rx_done && !rx_done_q;
  assign pop      = out_valid && out_ready;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && !push;

  assign sample_wide = offset_to_q(data_in, OUT_W);
  assign sample      = sample_wide[OUT_W-1:0];

  // A fresh drop outranks a clear in the same cycle so no loss goes unreported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (sample),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : head;

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Bench for adc_sample_conditioner: a cycle model with a scoreboard queue checks every
// cycle, while table-driven and directed sequences check the specific scenarios.
module tb_adc_sample_conditioner;

  typedef struct {
    logic [11:0] data;
    logic [15:0] exp;
  } conv_vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        rx_done = 1'b0;
  logic [11:0] data_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [3:0]  level;
  logic        overflow;
  logic        clr_ovf = 1'b0;

  int checks = 0;
  int fails  = 0;

  logic [15:0] sb[$];
  int          m_level = 0;
  logic        m_rxq = 1'b0;
  logic        m_ovf = 1'b0;

  adc_sample_conditioner #(.OUT_W(16), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rx_done   (rx_done),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] conv(input logic [11:0] d);
    return {~d[11], d[10:0], 4'h0};
  endfunction

  // Inputs change only just after a rising edge; the model samples on the falling edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic [11:0] d);
    rx_done = 1'b1;
    data_in = d;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  // Cycle model and scoreboard: expected samples are queued when a push is
  // predicted and compared against the head on every visible cycle.
  always @(negedge clk) begin
    bit req, pop, acc;
    if (rst) begin
      m_rxq   = 1'b0;
      m_level = 0;
      m_ovf   = 1'b0;
      sb.delete();
    end else begin
      check("mon_valid", 32'(out_valid), 32'(m_level != 0));
      check("mon_level", 32'(level), 32'(m_level));
      check("mon_ovf", 32'(overflow), 32'(m_ovf));
      if (m_level != 0) check("mon_head", 32'(out_data), 32'(sb[0]));
      else              check("mon_empty_data", 32'(out_data), 32'h0);
      pop = (m_level != 0) && out_ready;
      req = en && rx_done && !m_rxq;
      acc = req && (m_level < 8 || pop);
      if (pop) void'(sb.pop_front());
      if (acc) sb.push_back(conv(data_in));
      m_level = m_level + (acc ? 1 : 0) - (pop ? 1 : 0);
      if (req && !acc)  m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      m_rxq = rx_done;
    end
  end

  initial begin
    conv_vec_t vecs[4];
    int n;
    vecs[0] = '{data: 12'h000, exp: 16'h8000};
    vecs[1] = '{data: 12'h800, exp: 16'h0000};
    vecs[2] = '{data: 12'hFFF, exp: 16'h7FF0};
    vecs[3] = '{data: 12'h7FF, exp: 16'hFFF0};

    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);
    rst = 1'b0;
    en  = 1'b1;
    tick();

    // 1. conversion table, one-cycle capture-to-valid
    for (int i = 0; i < 4; i++) begin
      rx_done = 1'b1;
      data_in = vecs[i].data;
      tick();
      check("conv_valid", 32'(out_valid), 32'h1);
      check("conv_data", 32'(out_data), 32'(vecs[i].exp));
      rx_done   = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("conv_drained", 32'(level), 32'h0);
    end

    // 2. level-held strobe and disabled capture
    rx_done = 1'b1;
    data_in = 12'hA5A;
    for (int i = 0; i < 20; i++) tick();
    check("held_level", 32'(level), 32'h1);
    check("held_data", 32'(out_data), 32'h25A0);
    rx_done = 1'b0;
    tick();
    en      = 1'b0;
    rx_done = 1'b1;
    data_in = 12'h123;
    tick();
    en = 1'b1;
    tick();
    tick();
    rx_done = 1'b0;
    tick();
    check("en_low_level", 32'(level), 32'h1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 3. fill past capacity, drain, clear overflow
    for (int i = 1; i <= 9; i++) pulse(12'(i));
    check("fill_level", 32'(level), 32'h8);
    check("fill_ovf", 32'(overflow), 32'h1);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("drain_data", 32'(out_data), 32'(16'h8000 | (16'(i) << 4)));
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", 32'(level), 32'h0);
    check("ovf_sticky", 32'(overflow), 32'h1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'h0);

    // 4. full FIFO with push and pop on the same edge
    for (int i = 0; i < 8; i++) pulse(12'h100 + 12'(i));
    check("full_level", 32'(level), 32'h8);
    rx_done   = 1'b1;
    data_in   = 12'h0AB;
    out_ready = 1'b1;
    tick();
    rx_done = 1'b0;
    check("pp_level", 32'(level), 32'h8);
    check("pp_ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < 7; i++) tick();
    check("pp_order", 32'(out_data), 32'h8AB0);
    check("pp_last", 32'(level), 32'h1);
    tick();
    out_ready = 1'b0;

    // 5. backpressure: head holds while more samples arrive
    rx_done = 1'b1;
    data_in = 12'h333;
    tick();
    rx_done = 1'b0;
    tick();
    n = 1;
    for (int c = 0; c < 10; c++) begin
      rx_done = (c % 3 == 0);
      data_in = 12'h400 + 12'(c);
      tick();
      if (c % 3 == 0) n++;
      check("bp_data", 32'(out_data), 32'hB330);
      check("bp_level", 32'(level), 32'(n));
    end
    rx_done   = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    out_ready = 1'b0;

    // 6. asynchronous reset mid-operation, rx_done held across release
    for (int i = 0; i < 5; i++) pulse(12'h200 + 12'(i));
    check("pre_rst_level", 32'(level), 32'h5);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_level", 32'(level), 32'h0);
    check("arst_ovf", 32'(overflow), 32'h0);
    rx_done = 1'b1;
    data_in = 12'h7AB;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
    check("rel_level", 32'(level), 32'h1);
    check("rel_data", 32'(out_data), 32'hFAB0);
    tick();
    check("rel_once", 32'(level), 32'h1);
    rx_done   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/adc_sample_conditioner.md
Name: adc_sample_conditioner

Overview:
Sits directly downstream of the serial ADC receiver (ADC). It captures each 12-bit conversion on the receiver's rx_done and converts it from offset-binary to left-justified two's complement. Samples are buffered in a small FIFO and presented to the equalizer filter bank over a valid/ready handshake. Provides fill level and a sticky overflow flag for debug.

Parameters:
OUT_W, 16, output sample width; Q1.(OUT_W-1) two's complement; legal range 12..24
DEPTH, 8, FIFO entries; power of two; legal range 2..64

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  1  capture enable; when low, rx_done events are ignored
rx_done  in  1  conversion-complete level from ADC; may stay high for many cycles
data_in  in  12  ADC data_out, offset binary, valid while rx_done is high
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_data this cycle
out_data  out  OUT_W  head sample, two's complement, left-justified
level  out  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
overflow  out  1  sticky flag: a sample was dropped because the FIFO was full
clr_ovf  in  1  synchronous clear of overflow

Behaviour:
- Reset (async assert, released synchronously to clk):
  - rx_done_q=0, wr_ptr=0, rd_ptr=0, level=0, overflow=0.
  - out_valid=0; out_data=0 while empty.
  - FIFO storage is not reset.
- Capture:
  - A push request occurs at the clk edge where en=1, rx_done=1 and rx_done_q=0.
  - rx_done_q registers rx_done every cycle, independent of en.
  - A level held high for N cycles yields exactly one push.
  - rx_done rising while en=0 is lost; raising en later with rx_done already high does not capture.
- Conversion (combinational before write):
  - stored = {~data_in[11], data_in[10:0], (OUT_W-12) zeros}.
  - Examples: 12'h000 -> most-negative; 12'h800 -> 0; 12'hFFF -> max minus LSB pad.
- Pop: occurs at a clk edge where out_valid=1 and out_ready=1; rd_ptr increments.
- Data path and pointers:
  - out_data = mem[rd_ptr], combinational read.
  - out_valid = (level != 0).
  - Pointers wrap modulo DEPTH.
- Latency: a push at edge k makes out_valid=1 and out_data valid immediately after edge k (1-cycle capture-to-valid).
- Push accept rule: accepted if level<DEPTH, or if a pop occurs in the same cycle.
  - Full with simultaneous push and pop: both happen; level stays DEPTH; order is preserved.
  - Empty with simultaneous push and pop: no pop possible (out_valid=0); push only.
- Overflow:
  - A push request refused because the FIFO is full sets overflow=1; the new sample is discarded and existing contents are kept.
  - overflow stays set until clr_ovf=1 at a clock edge, or reset.
  - If clr_ovf coincides with a new drop, set wins (overflow stays 1).
- level: +1 on accepted push only, -1 on pop only, unchanged on both or neither.
- Mid-operation reset empties the FIFO instantly.
  - An rx_done held high across reset release is treated as a new rising edge (rx_done_q=0), so one push occurs on the first edge after release if en=1.
- out_data must be held stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package eq_pkg holds:
  - ADC_W=12.
  - A function offset_to_q(data, OUT_W) for reuse by the DAC-side inverse.
- One natural sub-module: sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, level, full, empty).
- Edge detection, conversion and overflow logic stay in the top.

Test Plan:
1. Conversion: OUT_W=16, en=1, rx_done pulses with data_in 12'h000, 12'h800, 12'hFFF, 12'h7FF, out_ready=1 -> out_data 16'h8000, 16'h0000, 16'h7FF0, 16'hFFF0, each valid 1 cycle after its rx_done rising edge.
2. Level-held strobe: rx_done high for 20 cycles with data_in=12'hA5A -> exactly one entry (level=1, out_data=16'h25A0); en=0 during a pulse -> level unchanged.
3. Fill/overflow:
   - out_ready=0; push 9 samples 12'h001..12'h009 -> level=8, overflow=1.
   - Drain yields 12'h001..12'h008 converted (16'h8010..16'h8080); 12'h009 is absent.
   - clr_ovf pulse -> overflow=0.
4. Full with simultaneous push/pop: FIFO full, out_ready=1 on the same edge as the rx_done rise -> level stays 8, overflow stays 0, and the new sample emerges 8 pops later.
5. Backpressure stability: out_valid=1, out_ready=0 for 10 cycles while further samples are pushed -> out_data constant, level increments per push.
6. Mid-operation reset: level=5, assert rst asynchronously between edges -> out_valid=0, level=0, overflow=0 immediately. After release with rx_done held high and en=1 -> one push on the first edge.
